// File: rtl/scandoubler_pkg.sv
// Shared constants and scan_mode encodings for the video scandoubler.
package scandoubler_pkg;

    localparam int SD_LINE_LEN = 896;
    localparam int SD_HSYNC_W  = 54;

    typedef enum logic [1:0] {
        SCAN_OFF = 2'b00,
        SCAN_75  = 2'b01,
        SCAN_50  = 2'b10,
        SCAN_25  = 2'b11
    } scan_mode_e;

endpackage

// File: rtl/sd_linebuf.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Contents are never reset.
module sd_linebuf #(
    parameter int DEPTH = 1792,
    parameter int DW    = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write on strobe, read data registered one cycle after the address
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_scandoubler_gen.sv
// Line-doubling scan converter: 14 MHz pixels in, each line replayed twice
// at 28 MHz from a ping-pong line buffer. Optional scanline attenuation on
// odd output lines is built only when SCANDOUBLER_SCANLINES_EN is defined.
module video_scandoubler_gen
    import scandoubler_pkg::*;
#(
    parameter int CW       = 3,
    parameter int LINE_LEN = SD_LINE_LEN,
    parameter int HSYNC_W  = SD_HSYNC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk14en,
    input  logic          enable_scandoubling,
    input  logic [1:0]    scan_mode,
    input  logic [CW-1:0] ri,
    input  logic [CW-1:0] gi,
    input  logic [CW-1:0] bi,
    input  logic          hsync_ext_n,
    input  logic          vsync_ext_n,
    input  logic          csync_ext_n,
    output logic [CW-1:0] ro,
    output logic [CW-1:0] go,
    output logic [CW-1:0] bo,
    output logic          hsync,
    output logic          vsync
);
    localparam int AW  = $clog2(LINE_LEN + 1);   // must hold LINE_LEN itself
    localparam int RAW = $clog2(2 * LINE_LEN);
    localparam int DW  = 3 * CW;
    // read address never exceeds line_len-1, so a wider pulse is the same as LINE_LEN
    localparam int HS_CLAMP = (HSYNC_W > LINE_LEN) ? LINE_LEN : HSYNC_W;
    localparam logic [AW-1:0] LEN_MAX = AW'(LINE_LEN);
    localparam logic [AW-1:0] HS_LIM  = AW'(HS_CLAMP);

    logic          hs_prev_q, line_start;
    logic [AW-1:0] wr_addr_q, wr_addr_d, wr_ptr;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] line_len_q, line_len_d;
    logic          bank_q, bank_d, wr_bank, we;
    logic          odd_q, odd_d, line_ok_q, line_ok_d, vs_q, vs_d;
    logic          blank, rd_wrap;
    logic [RAW-1:0] waddr, raddr;
    logic [DW-1:0]  rdata;
    logic          s1_odd_q, s1_blank_q, s1_hs_q;
    logic [CW-1:0] pr, pg, pb;
    logic [CW-1:0] ro_q, go_q, bo_q, ro_d, go_d, bo_d;
    logic          hs_out_q, hs_out_d, vs_out_q, vs_out_d;

    assign line_start = hs_prev_q & ~hsync_ext_n;
    assign blank      = (line_len_q == '0);
    assign rd_wrap    = !blank && (rd_addr_q == line_len_q - AW'(1));
    // bank_q is the write bank; the other one is replayed
    assign waddr = RAW'(wr_ptr) + (wr_bank ? RAW'(LINE_LEN) : RAW'(0));
    assign raddr = RAW'(rd_addr_q) + (bank_q ? RAW'(0) : RAW'(LINE_LEN));

    sd_linebuf #(.DEPTH(2 * LINE_LEN), .DW(DW), .AW(RAW)) u_linebuf (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i ({ri, gi, bi}),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

`ifdef SCANDOUBLER_SCANLINES_EN
    function automatic logic [CW-1:0] atten(input logic [CW-1:0] c, input logic [1:0] m);
        logic [CW+1:0] w;
        w = {2'b00, c};
        case (m)
            SCAN_75: w = (w * (CW+2)'(3)) >> 2;
            SCAN_50: w = w >> 1;
            SCAN_25: w = w >> 2;
            default: w = {2'b00, c};
        endcase
        return w[CW-1:0];
    endfunction
`else
    logic unused_scan;
    assign unused_scan = ^{scan_mode, s1_odd_q};
`endif

    // Write/read address, bank swap and line-length bookkeeping
    always_comb begin
        // a boundary with a coincident strobe writes address 0 of the new bank
        wr_ptr     = line_start ? '0 : wr_addr_q;
        wr_bank    = bank_q ^ line_start;
        we         = clk14en && (wr_ptr < LEN_MAX);
        wr_addr_d  = we ? wr_ptr + AW'(1) : wr_ptr;
        bank_d     = wr_bank;
        line_ok_d  = line_ok_q | line_start;
        line_len_d = line_len_q;
        vs_d       = vs_q;
        if (line_start) begin
            // the partial line seen before the first boundary is discarded
            line_len_d = line_ok_q ? wr_addr_q : '0;
            vs_d       = vsync_ext_n;
        end
        odd_d     = odd_q ^ rd_wrap;
        rd_addr_d = rd_addr_q;
        if (line_start || rd_wrap) rd_addr_d = '0;
        else if (!blank)           rd_addr_d = rd_addr_q + AW'(1);
    end

    // Output select: scandoubled pixel (blanked/attenuated) or passthrough
    always_comb begin
        {pr, pg, pb} = rdata;
`ifdef SCANDOUBLER_SCANLINES_EN
        if (s1_odd_q) begin
            pr = atten(pr, scan_mode);
            pg = atten(pg, scan_mode);
            pb = atten(pb, scan_mode);
        end
`endif
        if (s1_blank_q) {pr, pg, pb} = '0;
        if (enable_scandoubling) begin
            {ro_d, go_d, bo_d} = {pr, pg, pb};
            hs_out_d = s1_hs_q;
            vs_out_d = vs_q;
        end else begin
            {ro_d, go_d, bo_d} = {ri, gi, bi};
            hs_out_d = csync_ext_n;
            vs_out_d = 1'b1;
        end
    end

    // State, one pipeline stage alongside the RAM read, then output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev_q  <= 1'b1;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            line_len_q <= '0;
            bank_q     <= 1'b0;
            odd_q      <= 1'b0;
            line_ok_q  <= 1'b0;
            vs_q       <= 1'b1;
            s1_odd_q   <= 1'b0;
            s1_blank_q <= 1'b1;
            s1_hs_q    <= 1'b1;
            ro_q       <= '0;
            go_q       <= '0;
            bo_q       <= '0;
            hs_out_q   <= 1'b1;
            vs_out_q   <= 1'b1;
        end else begin
            hs_prev_q  <= hsync_ext_n;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            line_len_q <= line_len_d;
            bank_q     <= bank_d;
            odd_q      <= odd_d;
            line_ok_q  <= line_ok_d;
            vs_q       <= vs_d;
            s1_odd_q   <= odd_q;
            s1_blank_q <= blank;
            s1_hs_q    <= blank || (rd_addr_q >= HS_LIM);
            ro_q       <= ro_d;
            go_q       <= go_d;
            bo_q       <= bo_d;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
        end
    end

    assign ro    = ro_q;
    assign go    = go_q;
    assign bo    = bo_q;
    assign hsync = hs_out_q;
    assign vsync = vs_out_q;

endmodule

// File: tb/tb_video_scandoubler_gen.sv
// Directed bench for video_scandoubler_gen (default parameters).
module tb_video_scandoubler_gen;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk14en = 1'b0;
    logic          en = 1'b1;
    logic [1:0]    scan_mode = 2'b00;
    logic [CW-1:0] ri = '0, gi = '0, bi = '0;
    logic          hs_n = 1'b1, vs_n = 1'b1, cs_n = 1'b1;
    logic [CW-1:0] ro, go, bo;
    logic          hsync, vsync;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    video_scandoubler_gen dut (
        .clk                 (clk),
        .rst                 (rst),
        .clk14en             (clk14en),
        .enable_scandoubling (en),
        .scan_mode           (scan_mode),
        .ri                  (ri),
        .gi                  (gi),
        .bi                  (bi),
        .hsync_ext_n         (hs_n),
        .vsync_ext_n         (vs_n),
        .csync_ext_n         (cs_n),
        .ro                  (ro),
        .go                  (go),
        .bo                  (bo),
        .hsync               (hsync),
        .vsync               (vsync)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // expected odd-line attenuation of one channel
    function automatic int att(input int c, input int m);
        case (m)
`ifdef SCANDOUBLER_SCANLINES_EN
            1: return (3 * c) >> 2;
            2: return c >> 1;
            3: return c >> 2;
`endif
            default: return c;
        endcase
    endfunction

    // One input line of npix pixels (2 clk each); hsync_ext_n low for 32 clk
    // at the start. Outputs seen at iteration c come from stored pixel k=c-3
    // of the previous line (exp_len pixels, exp_pat 1 = constant 7, else ramp).
    // exp_len 0 means black is expected. rst_at>=0 pulses rst for 2 clk there.
    task automatic drive_line(input int npix, input int pat, input logic vs,
                              input int exp_len, input int exp_pat, input int rst_at);
        int k, pos, odd, base, er, eb, pix;
        for (int c = 0; c < 2 * npix; c++) begin
            hs_n    = (c < 32) ? 1'b0 : 1'b1;
            cs_n    = hs_n;
            vs_n    = vs;
            clk14en = (c % 2 == 0);
            pix     = pat ? 7 : (c / 2) % 8;
            ri      = CW'(pix);
            gi      = CW'(pix);
            bi      = CW'(7 - pix);
            if (rst_at >= 0) rst = (c >= rst_at) && (c < rst_at + 2);
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk("rst_ro", ro, 0);
                chk("rst_go", go, 0);
                chk("rst_bo", bo, 0);
                chk("rst_hsync", hsync, 1);
                chk("rst_vsync", vsync, 1);
            end else if (c >= 3 && (rst_at < 0 || c > rst_at + 1)) begin
                k = c - 3;
                if (exp_len == 0 || rst_at >= 0) begin
                    chk("blk_ro", ro, 0);
                    chk("blk_go", go, 0);
                    chk("blk_bo", bo, 0);
                    chk("blk_vsync", vsync, vs);
                end else begin
                    pos  = k % exp_len;
                    odd  = (k / exp_len) % 2;
                    base = exp_pat ? 7 : pos % 8;
                    er   = odd ? att(base, scan_mode) : base;
                    eb   = odd ? att(7 - base, scan_mode) : 7 - base;
                    chk("ro", ro, er);
                    chk("go", go, er);
                    chk("bo", bo, eb);
                    chk("hsync", hsync, (pos < 54) ? 0 : 1);
                    chk("vsync", vsync, vs);
                end
            end
            step();
        end
    endtask

    int pt_v[8]  = '{5, 2, 7, 0, 3, 6, 1, 4};
    int pt_cs[8] = '{0, 1, 1, 0, 1, 0, 0, 1};

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk("init_ro", ro, 0);
        chk("init_go", go, 0);
        chk("init_bo", bo, 0);
        chk("init_hsync", hsync, 1);
        chk("init_vsync", vsync, 1);
        rst = 1'b0;
        step();
        step();

        // ramp lines, no attenuation
        scan_mode = 2'b00;
        drive_line(896, 0, 1'b1,   0, 0, -1);
        drive_line(896, 0, 1'b1, 896, 0, -1);
        drive_line(896, 0, 1'b1, 896, 0, -1);

        // constant colour 7 with scanline modes
        scan_mode = 2'b10;
        drive_line(896, 1, 1'b1, 896, 0, -1);
        drive_line(896, 1, 1'b0, 896, 1, -1);
        scan_mode = 2'b11;
        drive_line(896, 1, 1'b1, 896, 1, -1);
        scan_mode = 2'b01;
        drive_line(1000, 0, 1'b1, 896, 1, -1);

        // overlong line clipped to 896, then a short 400-pixel line
        scan_mode = 2'b00;
        drive_line(896, 0, 1'b1, 896, 0, -1);
        drive_line(400, 0, 1'b1, 896, 0, -1);
        drive_line(896, 0, 1'b1, 400, 0, -1);

        // passthrough
        en      = 1'b0;
        clk14en = 1'b0;
        hs_n    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ri   = CW'(pt_v[i]);
            gi   = CW'(pt_v[7 - i]);
            bi   = ~CW'(pt_v[i]);
            cs_n = pt_cs[i][0];
            step();
            chk("pt_ro", ro, pt_v[i]);
            chk("pt_go", go, pt_v[7 - i]);
            chk("pt_bo", bo, 7 - pt_v[i]);
            chk("pt_hsync", hsync, pt_cs[i]);
            chk("pt_vsync", vsync, 1);
        end
        en = 1'b1;

        // reset mid-line: black until the second following boundary
        drive_line(896, 0, 1'b1,   0, 0, 500);
        drive_line(896, 0, 1'b0,   0, 0, -1);
        drive_line(896, 0, 1'b1, 896, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_scandoubler_gen.md
VIDEO_SCANDOUBLER_GEN -- requirements
Module: video_scandoubler_gen

Interface
REQ-001 SHALL have parameter CW, default 3: colour bits per channel.
REQ-002 SHALL have parameter LINE_LEN, default 896: maximum input pixels per line (line-buffer depth).
REQ-003 SHALL have parameter HSYNC_W, default 54: output hsync pulse width, in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, 28 MHz.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port clk14en, input, 1 bit: input pixel strobe, one clk cycle in every two.
REQ-007 SHALL have port enable_scandoubling, input, 1 bit: 1 = VGA rate output, 0 = passthrough.
REQ-008 SHALL have port scan_mode, input, 2 bits: scanline attenuation select.
REQ-009 SHALL have ports ri, gi, bi, input, CW bits each: input colour.
REQ-010 SHALL have ports hsync_ext_n, vsync_ext_n, csync_ext_n, input, 1 bit each: input syncs, active-low.
REQ-011 SHALL have ports ro, go, bo, output, CW bits each: output colour.
REQ-012 SHALL have ports hsync and vsync, output, 1 bit each: output syncs, active-low.

Function
REQ-013 SHALL store pixels in two line banks of LINE_LEN entries, used ping-pong.
  - Writes occur into the write bank only on clk14en.
  - Each write stores {ri,gi,bi} and increments the write address.
REQ-014 SHALL treat a falling edge of hsync_ext_n, sampled on clk, as a line boundary. On each boundary it SHALL:
  - latch the write address as line_len_q;
  - clear the write address;
  - swap the banks;
  - clear the read address.
REQ-015 SHALL give a boundary coincident with clk14en precedence: that pixel is written at address 0 of the new bank.
REQ-016 SHALL, when the write address reaches LINE_LEN, suppress further writes and hold the address at LINE_LEN (no wrap).
REQ-017 SHALL increment the read address every clk in the read bank.
  - When it reaches line_len_q-1 it SHALL wrap to 0 and toggle out_line_odd.
  - This produces two output lines per input line.
REQ-018 SHALL, if line_len_q is 0 (the first line after reset), hold the read address at 0 and output black.
REQ-019 SHALL assert output hsync low for HSYNC_W clk cycles starting at read address 0 of each output line.
  - If line_len_q is less than HSYNC_W, the pulse is truncated at the wrap.
REQ-020 SHALL drive output vsync as vsync_ext_n resampled at each input line boundary, i.e. delayed by one input line.
REQ-021 SHALL register the colour output: a pixel appears on ro/go/bo 2 clk cycles after its read address is presented; hsync is delayed equally.
REQ-022 SHALL, on odd output lines, attenuate each channel c according to scan_mode. Products use CW+2 bits, truncated.
  - 00: c
  - 01: (3c)>>2
  - 10: c>>1
  - 11: c>>2
REQ-023 SHALL leave even output lines unattenuated.
REQ-024 SHALL, with enable_scandoubling=0, output ro/go/bo = ri/gi/bi registered one cycle, hsync = csync_ext_n registered, and vsync = 1.
  - The buffer logic keeps running, so a mode change takes effect without reset.
REQ-025 SHALL apply an enable_scandoubling change from the next clk; no line resynchronisation is required.

Reset
REQ-026 SHALL, on rst, clear both addresses, line_len_q, out_line_odd and the bank select.
REQ-027 SHALL hold outputs during rst at ro=go=bo=0 and hsync=vsync=1.
REQ-028 SHALL, on rst asserted mid-line, discard partial lines; the first valid output follows the second boundary after rst deassertion.
REQ-029 SHALL NOT clear line-buffer contents on reset.

Configuration
REQ-030 SHALL use macro SCANDOUBLER_SCANLINES_EN.
  - Defined: attenuation is applied per REQ-022.
  - Undefined: scan_mode is ignored, all lines are unattenuated, and no multiplier/shift logic is generated.

Structure
REQ-031 SHALL take the scan_mode encodings (SCAN_OFF, SCAN_75, SCAN_50, SCAN_25) and the default LINE_LEN/HSYNC_W constants from shared package scandoubler_pkg.
REQ-032 SHALL instantiate one sub-module, sd_linebuf: a simple dual-port RAM, 2*LINE_LEN x 3*CW, one write port and one registered read port.

Verification
REQ-033 SHALL cover this scenario: reset, then three 896-pixel lines with ramp colour (pixel n = n mod 8) -> from the third line, each line is output twice, hsync low 54 cycles per 896-cycle output line, and ro sequence 0..7 repeating.
REQ-034 SHALL cover this scenario: scan_mode=10, constant input colour 7 -> even lines ro=7, odd lines ro=3; scan_mode=11 -> odd lines ro=1; macro undefined -> odd lines ro=7.
REQ-035 SHALL cover this scenario: a 1000-pixel input line -> write address saturates at 896 and the output line length is 896 cycles.
REQ-036 SHALL cover this scenario: a 400-pixel line following 896-pixel lines -> line_len_q=400 and the output lines are 400 cycles with a full 54-cycle hsync.
REQ-037 SHALL cover this scenario: enable_scandoubling=0 -> ro equals ri one cycle later, hsync tracks csync_ext_n, vsync=1.
REQ-038 SHALL cover this scenario: rst pulsed mid-line -> next cycle outputs are 0/1/1, and output is black until the second subsequent hsync_ext_n falling edge.
